// File: rtl/systolic_feed_ctrl.sv
// Sequencer for the SIZE x SIZE systolic multiply array: snapshots operands, clears, feeds skewed edges, drains.
// Optional completed-job counter enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_feed_ctrl #(
    parameter int unsigned WIDTHx = 5,
    parameter int unsigned SIZE   = 5,
    parameter int unsigned CNTW   = $clog2(3 * SIZE)
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              start,
    output logic              ready,
    output logic              busy,
    input  logic [WIDTHx-1:0] a_matrix [SIZE][SIZE],
    input  logic [WIDTHx-1:0] b_matrix [SIZE][SIZE],
    output logic [WIDTHx-1:0] a_edge   [SIZE],
    output logic [WIDTHx-1:0] b_edge   [SIZE],
    output logic              feed_valid,
    output logic              acc_clear,
    output logic              done,
    output logic [15:0]       job_count
);

    localparam int unsigned IDXW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CNTW-1:0] LAST_BEAT  = CNTW'(2 * SIZE - 2);
    localparam logic [CNTW-1:0] LAST_DRAIN = CNTW'(SIZE - 1);
    localparam logic [CNTW-1:0] SIZE_C     = CNTW'(SIZE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTHx-1:0] snap_a_q [SIZE][SIZE];
    logic [WIDTHx-1:0] snap_a_d [SIZE][SIZE];
    logic [WIDTHx-1:0] snap_b_q [SIZE][SIZE];
    logic [WIDTHx-1:0] snap_b_d [SIZE][SIZE];
    logic [WIDTHx-1:0] a_edge_q [SIZE];
    logic [WIDTHx-1:0] a_edge_d [SIZE];
    logic [WIDTHx-1:0] b_edge_q [SIZE];
    logic [WIDTHx-1:0] b_edge_d [SIZE];
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              feed_valid_q, feed_valid_d;
    logic              acc_clear_q, acc_clear_d;
    logic              done_q, done_d;

    logic              accept;
    logic              load_beat;
    logic [CNTW-1:0]   beat;
    logic [CNTW-1:0]   idx;

    // Next state, counter, snapshot and the registered value of every output.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        snap_a_d     = snap_a_q;
        snap_b_d     = snap_b_q;
        accept       = 1'b0;
        load_beat    = 1'b0;
        beat         = '0;
        idx          = '0;
        ready_d      = 1'b0;
        busy_d       = 1'b0;
        feed_valid_d = 1'b0;
        acc_clear_d  = 1'b0;
        done_d       = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            a_edge_d[i] = '0;
            b_edge_d[i] = '0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                end
            end
            CLEAR: begin
                state_d   = FEED;
                cnt_d     = '0;
                load_beat = 1'b1;
                beat      = '0;
            end
            FEED: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d     = cnt_q + CNTW'(1);
                    load_beat = 1'b1;
                    beat      = cnt_q + CNTW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            DONE: begin
                if (start) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            state_d  = CLEAR;
            cnt_d    = '0;
            snap_a_d = a_matrix;
            snap_b_d = b_matrix;
        end

        ready_d      = (state_d == IDLE) || (state_d == DONE);
        busy_d       = (state_d != IDLE);
        acc_clear_d  = (state_d == CLEAR);
        done_d       = (state_d == DONE);
        feed_valid_d = load_beat;

        // Skewed window: row/column k sees element (beat - k) only while it lies inside [0, SIZE).
        if (load_beat) begin
            for (int i = 0; i < SIZE; i++) begin
                if (beat >= CNTW'(i)) begin
                    idx = beat - CNTW'(i);
                    if (idx < SIZE_C) begin
                        a_edge_d[i] = snap_a_q[i][IDXW'(idx)];
                        b_edge_d[i] = snap_b_q[IDXW'(idx)][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            feed_valid_q <= 1'b0;
            acc_clear_q  <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                a_edge_q[i] <= '0;
                b_edge_q[i] <= '0;
                for (int j = 0; j < SIZE; j++) begin
                    snap_a_q[i][j] <= '0;
                    snap_b_q[i][j] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            feed_valid_q <= feed_valid_d;
            acc_clear_q  <= acc_clear_d;
            done_q       <= done_d;
            a_edge_q     <= a_edge_d;
            b_edge_q     <= b_edge_d;
            snap_a_q     <= snap_a_d;
            snap_b_q     <= snap_b_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign feed_valid = feed_valid_q;
    assign acc_clear  = acc_clear_q;
    assign done       = done_q;
    assign a_edge     = a_edge_q;
    assign b_edge     = b_edge_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0] job_count_q, job_count_d;

    // Counts each DONE cycle, saturating at all-ones.
    always_comb begin
        job_count_d = job_count_q;
        if ((state_q == DONE) && (job_count_q != 16'hFFFF)) begin
            job_count_d = job_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            job_count_q <= 16'h0000;
        end else begin
            job_count_q <= job_count_d;
        end
    end

    assign job_count = job_count_q;
`else
    assign job_count = 16'h0000;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: job-timeline reference model, directed literal checks, then randomized traffic.
module tb_systolic_feed_ctrl;

    localparam int S = 5;
    localparam int W = 5;
    localparam int T = 3 * S;

    logic         clock = 1'b0;
    logic         nreset = 1'b0;
    logic         start = 1'b0;
    logic         ready, busy, feed_valid, acc_clear, done;
    logic [15:0]  job_count;
    logic [W-1:0] a_matrix [S][S];
    logic [W-1:0] b_matrix [S][S];
    logic [W-1:0] a_edge [S];
    logic [W-1:0] b_edge [S];

    int vectors = 0;
    int miscompares = 0;

    // Reference: rel = cycles since the accepting edge of the current job, -1 when none is running.
    int rel = -1;
    int exp_jobs = 0;
    int snap_a [S][S];
    int snap_b [S][S];

    always #5 clock = ~clock;

    systolic_feed_ctrl #(.WIDTHx(W), .SIZE(S)) dut (
        .clock      (clock),
        .nreset     (nreset),
        .start      (start),
        .ready      (ready),
        .busy       (busy),
        .a_matrix   (a_matrix),
        .b_matrix   (b_matrix),
        .a_edge     (a_edge),
        .b_edge     (b_edge),
        .feed_valid (feed_valid),
        .acc_clear  (acc_clear),
        .done       (done),
        .job_count  (job_count)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rel = -1;
            exp_jobs = 0;
        end else begin
            if (rel == T && exp_jobs < 65535) exp_jobs++;
            if ((rel < 0 || rel == T) && start) begin
                rel = 0;
                for (int i = 0; i < S; i++)
                    for (int j = 0; j < S; j++) begin
                        snap_a[i][j] = int'(a_matrix[i][j]);
                        snap_b[i][j] = int'(b_matrix[i][j]);
                    end
            end else if (rel == T) begin
                rel = -1;
            end else if (rel >= 0) begin
                rel++;
            end
        end
    end

    always @(negedge clock) begin
        int t, k, ea, eb;
        bit fv;
        fv = (rel >= 1) && (rel <= 2 * S - 1);
        t = rel - 1;
        check("ready", int'(ready), int'(rel < 0 || rel == T));
        check("busy", int'(busy), int'(rel >= 0));
        check("acc_clear", int'(acc_clear), int'(rel == 0));
        check("feed_valid", int'(feed_valid), int'(fv));
        check("done", int'(done), int'(rel == T));
        for (int i = 0; i < S; i++) begin
            k = t - i;
            ea = (fv && k >= 0 && k < S) ? snap_a[i][k] : 0;
            eb = (fv && k >= 0 && k < S) ? snap_b[k][i] : 0;
            check($sformatf("a_edge[%0d]", i), int'(a_edge[i]), ea);
            check($sformatf("b_edge[%0d]", i), int'(b_edge[i]), eb);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("job_count", int'(job_count), exp_jobs);
`else
        check("job_count", int'(job_count), 0);
`endif
    end

    task automatic load_pattern();
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                a_matrix[i][j] = W'(5 * i + j + 1);
                b_matrix[i][j] = W'(5 * i + j + 1);
            end
    endtask

    task automatic check_edges(input string tag, input int ea [S], input int eb [S]);
        for (int i = 0; i < S; i++) begin
            check($sformatf("%s a_edge[%0d]", tag, i), int'(a_edge[i]), ea[i]);
            check($sformatf("%s b_edge[%0d]", tag, i), int'(b_edge[i]), eb[i]);
        end
    endtask

    initial begin
        int lit0 [S];
        int lit4a [S];
        int lit4b [S];
        int lit8 [S];
        int dones;
        bit seen_done;
        lit0  = '{1, 0, 0, 0, 0};
        lit4a = '{5, 9, 13, 17, 21};
        lit4b = '{21, 17, 13, 9, 5};
        lit8  = '{0, 0, 0, 0, 25};
        load_pattern();

        // Reset state
        repeat (3) @(negedge clock);
        check("rst ready", int'(ready), 1);
        check("rst busy", int'(busy), 0);
        check("rst job_count", int'(job_count), 0);
        #2 nreset = 1'b1;
        @(negedge clock);

        // Single job, operands overwritten after accept
        #1 start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            if (k == 1) check("lit acc_clear", int'(acc_clear), 1);
            if (k == 2) check_edges("lit beat0", lit0, lit0);
            if (k == 6) check_edges("lit beat4", lit4a, lit4b);
            if (k == 10) check_edges("lit beat8", lit8, lit8);
            if (k == 15) check("lit done early", int'(done), 0);
            if (k == 16) check("lit done", int'(done), 1);
            if (k == 17) begin
                check("lit idle busy", int'(busy), 0);
                check("lit idle ready", int'(ready), 1);
            end
            #1;
            start = 1'b0;
            if (k == 3)
                for (int i = 0; i < S; i++)
                    for (int j = 0; j < S; j++) a_matrix[i][j] = '0;
        end
        load_pattern();

        // Start held high: two back-to-back jobs
        #1 start = 1'b1;
        dones = 0;
        seen_done = 1'b0;
        for (int n = 0; n < 60 && dones < 2; n++) begin
            @(negedge clock);
            if (seen_done) check("lit b2b acc_clear", int'(acc_clear), 1);
            seen_done = done;
            if (done) dones++;
            if (dones == 2) begin
                #1 start = 1'b0;
            end
        end
        check("b2b done count", dones, 2);
        start = 1'b0;
        repeat (2) @(negedge clock);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("lit job_count", int'(job_count), 3);
`else
        check("lit job_count", int'(job_count), 0);
`endif
        check("lit b2b idle", int'(busy), 0);

        // Reset during feed beat 3
        #1 start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            #1 start = 1'b0;
        end
        check("lit beat3 valid", int'(feed_valid), 1);
        #1 nreset = 1'b0;
        #1;
        check("abort feed_valid", int'(feed_valid), 0);
        check("abort busy", int'(busy), 0);
        check("abort ready", int'(ready), 1);
        check("abort a_edge[3]", int'(a_edge[3]), 0);
        @(negedge clock);
        #2 nreset = 1'b1;
        seen_done = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (done) seen_done = 1'b1;
        end
        check("abort no done", int'(seen_done), 0);
        #1 start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (k == 2) check_edges("lit rerun beat0", lit0, lit0);
            if (k == 16) check("lit rerun done", int'(done), 1);
            #1 start = 1'b0;
        end

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            #1;
            start = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < S; i++)
                for (int j = 0; j < S; j++) begin
                    a_matrix[i][j] = W'($urandom_range(0, 31));
                    b_matrix[i][j] = W'($urandom_range(0, 31));
                end
            if ($urandom_range(0, 199) == 0) begin
                #1 nreset = 1'b0;
                @(negedge clock);
                #2 nreset = 1'b1;
            end
        end
        start = 1'b0;
        repeat (T + 3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

- Sequencer for the SIZE×SIZE systolic matrix-multiply array (`top_mult_celula`).
- On a start handshake it snapshots both operand matrices and pulses an accumulator clear.
- It then drives the skewed west (A rows) and north (B columns) edge streams, waits for the array to drain, and signals completion.
- It sits between the job source and the array; the array's product output is captured downstream on `done`.

## Interface

Parameters:
- WIDTHx, 5, operand element width (bits).
- SIZE, 5, array dimension; legal range SIZE ≥ 2.
- CNTW, $clog2(3*SIZE), width of the internal beat/drain counter.

Ports:
- clock  in  1  single clock, rising edge.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only when `ready`=1.
- ready  out  1  controller can accept a job (state IDLE or DONE).
- busy  out  1  job in progress (state CLEAR, FEED, DRAIN or DONE).
- a_matrix  in  WIDTHx per element, [SIZE][SIZE] unpacked  operand A, indexed [row][col].
- b_matrix  in  WIDTHx per element, [SIZE][SIZE] unpacked  operand B, indexed [row][col].
- a_edge  out  WIDTHx per element, [SIZE] unpacked  west-edge feed, one element per array row.
- b_edge  out  WIDTHx per element, [SIZE] unpacked  north-edge feed, one element per array column.
- feed_valid  out  1  a_edge/b_edge carry a feed beat.
- acc_clear  out  1  one-cycle pulse; clears the array accumulators.
- done  out  1  one-cycle pulse; the array product is final.
- job_count  out  16  completed jobs (see Configuration).

## Operation

- Reset (nreset low, asynchronous):
  - state → IDLE.
  - All outputs → 0, except ready=1.
  - Snapshot registers and counter → 0.
- FSM: IDLE → CLEAR → FEED → DRAIN → DONE → (IDLE, or CLEAR if start=1).
- Accept:
  - start=1 with ready=1 at a rising edge latches a_matrix/b_matrix into the snapshot registers.
  - Later changes to a_matrix/b_matrix have no effect on that job.
  - start with ready=0 is ignored and is not queued.
- CLEAR: acc_clear=1 for exactly one cycle; counter → 0.
- FEED: beat t = 0 … 2·SIZE−2 (2·SIZE−1 cycles), feed_valid=1.
  - a_edge[i] = A[i][t−i] when 0 ≤ t−i < SIZE, else 0.
  - b_edge[j] = B[t−j][j] when 0 ≤ t−j < SIZE, else 0.
- DRAIN: SIZE cycles; feed_valid=0 and all edges 0.
- DONE: done=1 for one cycle. Next state is CLEAR if start=1 (back-to-back job), else IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Index arithmetic uses the unsigned counter. Out-of-window elements are forced to 0; no wrap-around into valid indices.

## Timing

- Edges are numbered E0 = rising edge at which start is accepted.
- acc_clear is high in cycle [E0, E1).
- Feed beat t is presented in [E1+t, E2+t).
- DRAIN occupies [E(2·SIZE), E(3·SIZE)).
- done is high in [E(3·SIZE), E(3·SIZE+1)). For SIZE=5: start-to-done latency is 15 cycles.
- busy is high from E0 through the DONE cycle. ready=0 from E0 until DONE is entered.
- Back-to-back: start accepted in DONE gives acc_clear in the cycle immediately after done, with no IDLE bubble.
- Reset mid-job: outputs clear immediately, with no done pulse. After reset release the FSM is in IDLE; the aborted job is not resumed.

## Configuration

- Macro: `SYSTOLIC_CTRL_PERF_EN`.
- Defined:
  - job_count increments by 1 in each DONE cycle.
  - It saturates at 16'hFFFF and resets to 0 on nreset.
- Undefined: job_count is tied to 0 and no counter logic is synthesized.

## Test plan

All scenarios use SIZE=5, WIDTHx=5, and A[i][j] = B[i][j] = 5i+j+1 (values 1…25).

- Single job, beat 0:
  - acc_clear=1 in the cycle after accept.
  - Beat 0: a_edge={1,0,0,0,0}, b_edge={1,0,0,0,0}.
- Single job, beats 4 and 8:
  - Beat 4: a_edge={5,9,13,17,21}, b_edge={21,17,13,9,5}.
  - Beat 8: a_edge={0,0,0,0,25}, b_edge={0,0,0,0,25}.
- Single job, completion: done pulses 15 cycles after accept; then busy=0 and ready=1.
- Start held high through a whole job → second job's acc_clear lands in the cycle right after the first done; starts during busy are not counted.
- Change a_matrix to all-zero 3 cycles after accept → edges still follow the snapshot values above.
- nreset low during FEED beat 3 → all outputs 0 immediately, with no done pulse; a new start after release runs a full job from beat 0.
- `SYSTOLIC_CTRL_PERF_EN` defined, three jobs run → job_count=3; macro undefined → job_count=0 throughout.
